// File: rtl/fwd_source_pipe_pkg.sv
// ---------------------------------------------------------------------------
// fwd_source_pipe_pkg
// Shared definitions for the operand-forwarding producer slice:
//   - forwarding mux select encodings seen by the consumer side
//   - a handful of opcode constants used by the surrounding core
//   - ZERO_32BIT and the packed stage-entry width FWD_STAGE_W
// A stage entry is packed MSB->LSB as {valid, rd, reg_wr, is_load, alu_result}.
// ---------------------------------------------------------------------------
package fwd_source_pipe_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int REG_ADDR_W_DEFAULT = 5;

  // Operand source selects used by the bypass consumer
  typedef enum logic [1:0] {
    FORWARD_ORG = 2'b00,
    FORWARD_MEM = 2'b01,
    FORWARD_WB  = 2'b10
  } forward_sel_e;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam logic [31:0] ZERO_32BIT = 32'h0000_0000;

  // Width of one packed stage entry: valid + reg_wr + is_load + rd + data
  function automatic int fwd_stage_w(input int xlen, input int reg_addr_w);
    return 3 + reg_addr_w + xlen;
  endfunction

  localparam int FWD_STAGE_W = fwd_stage_w(XLEN_DEFAULT, REG_ADDR_W_DEFAULT);

endpackage

// File: rtl/fwd_source_pipe_stage.sv
// ---------------------------------------------------------------------------
// fwd_pipe_stage
// One pipeline register holding a packed stage entry whose MSB is the valid bit.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset, clears the whole entry
//   hold_i  freeze the entry (takes priority over kill_i)
//   kill_i  capture d_i with the valid bit forced low (a bubble)
//   d_i     incoming entry
//   q_o     registered entry
// ---------------------------------------------------------------------------
module fwd_pipe_stage
  import fwd_source_pipe_pkg::*;
#(
  parameter int W = FWD_STAGE_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         hold_i,
  input  logic         kill_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] entry_q;
  logic [W-1:0] entry_d;

  // Hold wins over kill, so a kill raised during a hold only takes effect
  // on the first released cycle. A killed entry keeps its payload but is invalid.
  always_comb begin
    entry_d = entry_q;
    if (!hold_i) begin
      if (kill_i) begin
        entry_d = {1'b0, d_i[W-2:0]};
      end else begin
        entry_d = d_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/fwd_source_pipe.sv
// ---------------------------------------------------------------------------
// fwd_source_pipe
// Producer end of the operand-forwarding interface. Carries each EX result
// through EX/MEM and MEM/WB, drives the MEM/WB bypass sources and flags
// load-use hazards against the instruction in ID.
// Optional feature macro: FWD_PERF_CNT_EN (stall / retired-write counters).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   hold_i                       freeze both stages
//   ex_flush_i                   turn the EX instruction into a bubble
//   ex_valid_i, ex_rd_i, ex_reg_wr_i, ex_is_load_i, ex_alu_result_i
//                                EX instruction fields
//   id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i
//                                ID source operands
//   wb_load_data_i               load data for the load currently in WB
//   rd_mem_o, reg_file_wr_mem_o, fwd_mem_data_o   MEM bypass source
//   rd_wb_o, reg_file_wr_wb_o, fwd_wb_data_o      WB bypass source
//   load_use_stall_o             one-cycle stall request
//   perf_stall_cnt_o, perf_wb_cnt_o               performance counters
// ---------------------------------------------------------------------------
module fwd_source_pipe
  import fwd_source_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  hold_i,
  input  logic                  ex_flush_i,
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_reg_wr_i,
  input  logic                  ex_is_load_i,
  input  logic [XLEN-1:0]       ex_alu_result_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [XLEN-1:0]       wb_load_data_i,
  output logic [REG_ADDR_W-1:0] rd_mem_o,
  output logic [REG_ADDR_W-1:0] rd_wb_o,
  output logic                  reg_file_wr_mem_o,
  output logic                  reg_file_wr_wb_o,
  output logic [XLEN-1:0]       fwd_mem_data_o,
  output logic [XLEN-1:0]       fwd_wb_data_o,
  output logic                  load_use_stall_o,
  output logic [CNT_W-1:0]      perf_stall_cnt_o,
  output logic [CNT_W-1:0]      perf_wb_cnt_o
);

  localparam int STAGE_W = fwd_stage_w(XLEN, REG_ADDR_W);

  logic [STAGE_W-1:0] ex_entry;
  logic [STAGE_W-1:0] mem_entry;
  logic [STAGE_W-1:0] wb_entry;

  logic                  mem_valid, mem_reg_wr, mem_is_load;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_alu;
  logic                  wb_valid, wb_reg_wr, wb_is_load;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_alu;

  logic wr_mem, wr_wb, stall;

  assign ex_entry = {ex_valid_i, ex_rd_i, ex_reg_wr_i, ex_is_load_i, ex_alu_result_i};

  // Flush only kills the EX->MEM hop; MEM->WB never kills, it just copies.
  fwd_pipe_stage #(.W(STAGE_W)) u_ex_mem (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .hold_i (hold_i),
    .kill_i (ex_flush_i),
    .d_i    (ex_entry),
    .q_o    (mem_entry)
  );

  fwd_pipe_stage #(.W(STAGE_W)) u_mem_wb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .hold_i (hold_i),
    .kill_i (1'b0),
    .d_i    (mem_entry),
    .q_o    (wb_entry)
  );

  assign {mem_valid, mem_rd, mem_reg_wr, mem_is_load, mem_alu} = mem_entry;
  assign {wb_valid, wb_rd, wb_reg_wr, wb_is_load, wb_alu}      = wb_entry;

  // x0 writes are never advertised; a load in MEM has no data yet.
  assign wr_mem = mem_valid & mem_reg_wr & ~mem_is_load & (mem_rd != '0);
  assign wr_wb  = wb_valid & wb_reg_wr & (wb_rd != '0);

  // The bubble inserted by the stall moves the load to MEM, so this drops
  // by itself after one cycle.
  assign stall = ex_valid_i & ex_is_load_i & ex_reg_wr_i & (ex_rd_i != '0) & ~ex_flush_i
               & ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) | (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

  // All outputs read as zero while reset is asserted, even before the first edge.
  assign rd_mem_o          = rst_i ? '0 : mem_rd;
  assign rd_wb_o           = rst_i ? '0 : wb_rd;
  assign reg_file_wr_mem_o = ~rst_i & wr_mem;
  assign reg_file_wr_wb_o  = ~rst_i & wr_wb;
  assign fwd_mem_data_o    = rst_i ? '0 : mem_alu;
  assign fwd_wb_data_o     = rst_i ? '0 : (wb_is_load ? wb_load_data_i : wb_alu);
  assign load_use_stall_o  = ~rst_i & stall;

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

  // Saturating event counters; frozen cycles are not counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    wb_cnt_d    = wb_cnt_q;
    if (!hold_i) begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (wr_wb && (wb_cnt_q != '1)) begin
        wb_cnt_d = wb_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      wb_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
    end
  end

  assign perf_stall_cnt_o = rst_i ? '0 : stall_cnt_q;
  assign perf_wb_cnt_o    = rst_i ? '0 : wb_cnt_q;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_wb_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_fwd_source_pipe.sv
// ---------------------------------------------------------------------------
// tb_fwd_source_pipe
// Directed table, a few multi-cycle sequences and a randomized run for
// fwd_source_pipe, checked against an in-bench reference of in-flight
// instructions.
// ---------------------------------------------------------------------------
module tb_fwd_source_pipe;

  typedef struct {
    logic        rst, hold, flush, exValid;
    logic [4:0]  exRd;
    logic        exRegWr, exIsLoad;
    logic [31:0] exAlu;
    logic [4:0]  idRs1, idRs2;
    logic        useRs1, useRs2;
    logic [31:0] wbLoad;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [4:0]  rdMem;
    logic        wrMem;
    logic [31:0] memData;
    logic [4:0]  rdWb;
    logic        wrWb;
    logic [31:0] wbData;
    logic        stall;
  } vec_t;

  // One instruction in flight; slot 0 sits in MEM, slot 1 in WB
  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic        regWr, isLoad;
    logic [31:0] data;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst, hold, exFlush, exValid, exRegWr, exIsLoad, useRs1, useRs2;
  logic [4:0]  exRd, idRs1, idRs2;
  logic [31:0] exAlu, wbLoad;
  logic [4:0]  rdMem, rdWb;
  logic        wrMem, wrWb, stall;
  logic [31:0] memData, wbData, perfStall, perfWb;

  int vectors = 0;
  int miscompares = 0;

  instr_t inFlight[2];
  longint stallEvents = 0;
  longint wbEvents = 0;

  always #5 clk = ~clk;

  fwd_source_pipe dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .hold_i            (hold),
    .ex_flush_i        (exFlush),
    .ex_valid_i        (exValid),
    .ex_rd_i           (exRd),
    .ex_reg_wr_i       (exRegWr),
    .ex_is_load_i      (exIsLoad),
    .ex_alu_result_i   (exAlu),
    .id_rs1_i          (idRs1),
    .id_rs2_i          (idRs2),
    .id_use_rs1_i      (useRs1),
    .id_use_rs2_i      (useRs2),
    .wb_load_data_i    (wbLoad),
    .rd_mem_o          (rdMem),
    .rd_wb_o           (rdWb),
    .reg_file_wr_mem_o (wrMem),
    .reg_file_wr_wb_o  (wrWb),
    .fwd_mem_data_o    (memData),
    .fwd_wb_data_o     (wbData),
    .load_use_stall_o  (stall),
    .perf_stall_cnt_o  (perfStall),
    .perf_wb_cnt_o     (perfWb)
  );

  function automatic stim_t mkStim(input logic r, input logic h, input logic f, input logic v,
                                   input logic [4:0] rd, input logic wr, input logic ld,
                                   input logic [31:0] alu, input logic [4:0] rs1, input logic u1,
                                   input logic [31:0] wbld);
    stim_t s;
    s.rst = r; s.hold = h; s.flush = f; s.exValid = v; s.exRd = rd;
    s.exRegWr = wr; s.exIsLoad = ld; s.exAlu = alu; s.idRs1 = rs1; s.idRs2 = 5'd0;
    s.useRs1 = u1; s.useRs2 = 1'b0; s.wbLoad = wbld;
    return s;
  endfunction

  function automatic vec_t mkVec(input stim_t s, input logic [4:0] erm, input logic ewm,
                                 input logic [31:0] edm, input logic [4:0] erw, input logic eww,
                                 input logic [31:0] edw, input logic est);
    vec_t v;
    v.s = s; v.rdMem = erm; v.wrMem = ewm; v.memData = edm;
    v.rdWb = erw; v.wrWb = eww; v.wbData = edw; v.stall = est;
    return v;
  endfunction

  task automatic applyStimulus(input stim_t s);
    rst = s.rst; hold = s.hold; exFlush = s.flush; exValid = s.exValid;
    exRd = s.exRd; exRegWr = s.exRegWr; exIsLoad = s.exIsLoad; exAlu = s.exAlu;
    idRs1 = s.idRs1; idRs2 = s.idRs2; useRs1 = s.useRs1; useRs2 = s.useRs2;
    wbLoad = s.wbLoad;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: load-use hazard from the instruction-level rule
  function automatic logic refStall();
    if (rst || !exValid || exFlush || !exIsLoad || !exRegWr || exRd == 5'd0) return 1'b0;
    return (useRs1 && idRs1 == exRd) || (useRs2 && idRs2 == exRd);
  endfunction

  function automatic logic refWrWb();
    return !rst && inFlight[1].valid && inFlight[1].regWr && inFlight[1].rd != 5'd0;
  endfunction

  // Advance the reference by one clock using the inputs present at the edge
  task automatic modelEdge();
    instr_t fresh;
    if (rst) begin
      inFlight[0] = '{default: '0};
      inFlight[1] = '{default: '0};
      stallEvents = 0;
      wbEvents = 0;
    end else if (!hold) begin
      if (refStall()) stallEvents = stallEvents + 1;
      if (refWrWb()) wbEvents = wbEvents + 1;
      fresh.valid = exValid && !exFlush;
      fresh.rd = exRd; fresh.regWr = exRegWr; fresh.isLoad = exIsLoad; fresh.data = exAlu;
      inFlight[1] = inFlight[0];
      inFlight[0] = fresh;
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  function automatic logic [31:0] satCount(input longint n);
`ifdef FWD_PERF_CNT_EN
    if (rst) return 32'd0;
    return (n > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : n[31:0];
`else
    return (n < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic checkOutput(input string tag);
    instr_t m, w;
    m = inFlight[0];
    w = inFlight[1];
    if (rst) begin
      cmp({tag, ".rdMem"}, 32'(rdMem), 32'd0);
      cmp({tag, ".rdWb"}, 32'(rdWb), 32'd0);
      cmp({tag, ".wrMem"}, 32'(wrMem), 32'd0);
      cmp({tag, ".wrWb"}, 32'(wrWb), 32'd0);
      cmp({tag, ".memData"}, memData, 32'd0);
      cmp({tag, ".wbData"}, wbData, 32'd0);
    end else begin
      cmp({tag, ".rdMem"}, 32'(rdMem), 32'(m.rd));
      cmp({tag, ".rdWb"}, 32'(rdWb), 32'(w.rd));
      cmp({tag, ".wrMem"}, 32'(wrMem), 32'(m.valid && m.regWr && !m.isLoad && m.rd != 5'd0));
      cmp({tag, ".wrWb"}, 32'(wrWb), 32'(refWrWb()));
      cmp({tag, ".memData"}, memData, m.data);
      cmp({tag, ".wbData"}, wbData, w.isLoad ? wbLoad : w.data);
    end
    cmp({tag, ".stall"}, 32'(stall), 32'(refStall()));
    cmp({tag, ".perfStall"}, perfStall, satCount(stallEvents));
    cmp({tag, ".perfWb"}, perfWb, satCount(wbEvents));
  endtask

  vec_t table_q[$];
  stim_t idle;

  initial begin
    idle = mkStim(0, 0, 0, 0, 5'd0, 0, 0, 32'd0, 5'd0, 0, 32'd0);
    applyStimulus(mkStim(1, 0, 0, 0, 5'd0, 0, 0, 32'd0, 5'd0, 0, 32'd0));
    #1;
    checkOutput("resetComb");
    stepClock();
    stepClock();
    checkOutput("resetState");

    // Directed vectors: inputs, then expected outputs after one edge (inputs still applied)
    table_q.push_back(mkVec(mkStim(1,0,0,0,5'd0,0,0,32'h0,5'd0,0,32'h0), 5'd0,0,32'h0, 5'd0,0,32'h0, 0));
    table_q.push_back(mkVec(mkStim(0,0,0,1,5'd5,1,0,32'h10,5'd0,0,32'h0), 5'd5,1,32'h10, 5'd0,0,32'h0, 0));
    table_q.push_back(mkVec(idle, 5'd0,0,32'h0, 5'd5,1,32'h10, 0));
    table_q.push_back(mkVec(idle, 5'd0,0,32'h0, 5'd0,0,32'h0, 0));
    table_q.push_back(mkVec(mkStim(0,0,0,1,5'd7,1,1,32'h100,5'd7,1,32'h0), 5'd7,0,32'h100, 5'd0,0,32'h0, 1));
    table_q.push_back(mkVec(mkStim(0,0,0,0,5'd0,0,0,32'h0,5'd7,1,32'hCAFEF00D), 5'd0,0,32'h0, 5'd7,1,32'hCAFEF00D, 0));
    table_q.push_back(mkVec(mkStim(0,0,0,1,5'd0,1,0,32'h55,5'd0,0,32'h0), 5'd0,0,32'h55, 5'd0,0,32'h0, 0));
    table_q.push_back(mkVec(mkStim(0,0,0,1,5'd0,1,1,32'h60,5'd0,1,32'h0), 5'd0,0,32'h60, 5'd0,0,32'h55, 0));
    table_q.push_back(mkVec(mkStim(0,0,1,1,5'd3,1,0,32'h33,5'd0,0,32'h1234), 5'd3,0,32'h33, 5'd0,0,32'h1234, 0));
    table_q.push_back(mkVec(idle, 5'd0,0,32'h0, 5'd3,0,32'h33, 0));

    foreach (table_q[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      applyStimulus(table_q[i].s);
      stepClock();
      cmp({tag, ".rdMem"}, 32'(rdMem), 32'(table_q[i].rdMem));
      cmp({tag, ".wrMem"}, 32'(wrMem), 32'(table_q[i].wrMem));
      cmp({tag, ".memData"}, memData, table_q[i].memData);
      cmp({tag, ".rdWb"}, 32'(rdWb), 32'(table_q[i].rdWb));
      cmp({tag, ".wrWb"}, 32'(wrWb), 32'(table_q[i].wrWb));
      cmp({tag, ".wbData"}, wbData, table_q[i].wbData);
      cmp({tag, ".stall"}, 32'(stall), 32'(table_q[i].stall));
    end

    // Hold with live MEM/WB entries, a pending flush and a new EX instruction
    applyStimulus(mkStim(0,0,0,1,5'd9,1,0,32'hAA,5'd0,0,32'h0));
    stepClock();
    applyStimulus(mkStim(0,0,0,1,5'd10,1,0,32'hBB,5'd0,0,32'h0));
    stepClock();
    checkOutput("preHold");
    applyStimulus(mkStim(0,1,1,1,5'd11,1,0,32'hCC,5'd0,0,32'h0));
    for (int c = 0; c < 3; c++) begin
      stepClock();
      checkOutput($sformatf("hold%0d", c));
      cmp("holdRdMem", 32'(rdMem), 32'd10);
      cmp("holdRdWb", 32'(rdWb), 32'd9);
    end
    hold = 1'b0;
    stepClock();
    checkOutput("release0");
    cmp("releaseRdWb", 32'(rdWb), 32'd10);
    cmp("releaseWrMem", 32'(wrMem), 32'd0);
    applyStimulus(idle);
    stepClock();
    checkOutput("release1");

    // Reset with both stages full, then two load-use stalls
    applyStimulus(mkStim(0,0,0,1,5'd12,1,0,32'h77,5'd0,0,32'h0));
    stepClock();
    applyStimulus(mkStim(0,0,0,1,5'd13,1,0,32'h88,5'd0,0,32'h0));
    stepClock();
    rst = 1'b1;
    stepClock();
    checkOutput("midReset");
    cmp("midResetWrWb", 32'(wrWb), 32'd0);
    applyStimulus(idle);
    stepClock();
    checkOutput("afterReset");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(mkStim(0,0,0,1,5'd4,1,1,32'h40,5'd4,1,32'h0));
      #1;
      checkOutput($sformatf("stallPre%0d", k));
      stepClock();
      applyStimulus(mkStim(0,0,0,0,5'd0,0,0,32'h0,5'd4,1,32'h0));
      stepClock();
    end
    checkOutput("perfAfterStalls");
`ifdef FWD_PERF_CNT_EN
    cmp("perfStall2", perfStall, 32'd2);
`else
    cmp("perfStallTied", perfStall, 32'd0);
`endif

    // Randomized traffic with small register indices so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      stim_t s;
      s.rst      = ($urandom_range(0, 49) == 0);
      s.hold     = ($urandom_range(0, 7) == 0);
      s.flush    = ($urandom_range(0, 7) == 0);
      s.exValid  = ($urandom_range(0, 3) != 0);
      s.exRd     = 5'($urandom_range(0, 7));
      s.exRegWr  = ($urandom_range(0, 4) != 0);
      s.exIsLoad = ($urandom_range(0, 2) == 0);
      s.exAlu    = $urandom;
      s.idRs1    = 5'($urandom_range(0, 7));
      s.idRs2    = 5'($urandom_range(0, 7));
      s.useRs1   = $urandom_range(0, 1) == 1;
      s.useRs2   = $urandom_range(0, 1) == 1;
      s.wbLoad   = $urandom;
      applyStimulus(s);
      #1;
      checkOutput($sformatf("rndPre%0d", n));
      stepClock();
      checkOutput($sformatf("rndPost%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
